// File: rtl/gray_pkg.sv
// gray_pkg: Gray/binary conversion helpers shared by the counter and the decode stage
package gray_pkg;
  localparam int DEFAULT_WIDTH = 4;
  function automatic logic [31:0] bin_to_gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [31:0] gray_to_binary(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/gray_counter_if.sv
// gray_counter_if: control and Gray output bundle of the counter
interface gray_counter_if #(parameter int WIDTH = 4);
  logic             i_clr;
  logic             i_load;
  logic [WIDTH-1:0] i_load_bin;
  logic             i_en;
  logic             i_up;
  logic [WIDTH-1:0] o_gray;
  logic             o_valid;
  logic             o_wrap;
  modport master (output i_clr, i_load, i_load_bin, i_en, i_up, input o_gray, o_valid, o_wrap);
  modport slave  (input i_clr, i_load, i_load_bin, i_en, i_up, output o_gray, o_valid, o_wrap);
endinterface

// File: rtl/gray_counter.sv
// gray_counter: up/down counter with registered Gray output, wrap or saturate at terminal count
module gray_counter import gray_pkg::*; #(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit WRAP_MODE = 1'b1
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  gray_counter_if.slave  bus
);
  localparam logic [WIDTH-1:0] MAX = '1;
  logic [WIDTH-1:0] r_bin, r_gray, w_lim, w_step, w_next;
  logic             r_valid, r_wrap, w_at_lim, w_wrap;
  always_comb begin
    w_lim    = bus.i_up ? MAX : '0;
    w_step   = bus.i_up ? r_bin + WIDTH'(1) : r_bin - WIDTH'(1);
    w_at_lim = r_bin == w_lim;
    w_next   = bus.i_clr ? '0 : bus.i_load ? bus.i_load_bin : !bus.i_en ? r_bin :
               (w_at_lim && !WRAP_MODE) ? r_bin : w_step;
    // saturating mode flags only the step that lands on the limit, not the hold after it
    w_wrap   = !bus.i_clr && !bus.i_load && bus.i_en &&
               (WRAP_MODE ? w_at_lim : (!w_at_lim && w_step == w_lim));
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bin   <= '0;
      r_gray  <= '0;
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_bin   <= w_next;
      r_gray  <= WIDTH'(bin_to_gray(32'(w_next)));
      r_valid <= 1'b1;
      r_wrap  <= w_wrap;
    end
  end
  assign bus.o_gray  = r_gray;
  assign bus.o_valid = r_valid;
  assign bus.o_wrap  = r_wrap;
endmodule

// File: tb/tb_gray_counter.sv
// tb_gray_counter: randomized check of wrapping and saturating counters against an arithmetic model
module tb_gray_counter;
  import gray_pkg::*;
  localparam int W = 4;
  localparam int M = (1 << W) - 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0, n_err = 0;
  int c1 = 0, c0 = 0;
  bit w1 = 0, w0 = 0, mv = 0;
  int seq [16] = '{1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};
  int pulses;
  always #5 clk = ~clk;
  gray_counter_if #(.WIDTH(W)) if1();
  gray_counter_if #(.WIDTH(W)) if0();
  gray_counter #(.WIDTH(W), .WRAP_MODE(1'b1)) u_dut1 (.i_clk(clk), .i_rst_n(rst_n), .bus(if1));
  gray_counter #(.WIDTH(W), .WRAP_MODE(1'b0)) u_dut0 (.i_clk(clk), .i_rst_n(rst_n), .bus(if0));
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic model(input bit clr, load, input int lb, input bit en, up, mode, inout int c, output bit w);
    w = 0;
    if (clr) c = 0;
    else if (load) c = lb;
    else if (en && up) begin
      if (c == M) begin
        if (mode) begin c = 0; w = 1; end
      end else begin
        c = c + 1;
        w = !mode && c == M;
      end
    end else if (en) begin
      if (c == 0) begin
        if (mode) begin c = M; w = 1; end
      end else begin
        c = c - 1;
        w = !mode && c == 0;
      end
    end
  endtask
  task automatic compare_all();
    check("gray1", if1.o_gray, c1 ^ (c1 >> 1));
    check("wrap1", if1.o_wrap, w1);
    check("valid1", if1.o_valid, mv);
    check("dec1", gray_to_binary(32'(if1.o_gray)), c1);
    check("gray0", if0.o_gray, c0 ^ (c0 >> 1));
    check("wrap0", if0.o_wrap, w0);
    check("valid0", if0.o_valid, mv);
    check("dec0", gray_to_binary(32'(if0.o_gray)), c0);
  endtask
  task automatic step(input bit clr, load, input int lb, input bit en, up);
    int p1 = c1, p0 = c0;
    logic [W-1:0] g1 = if1.o_gray, g0 = if0.o_gray;
    if1.i_clr = clr; if1.i_load = load; if1.i_load_bin = W'(lb); if1.i_en = en; if1.i_up = up;
    if0.i_clr = clr; if0.i_load = load; if0.i_load_bin = W'(lb); if0.i_en = en; if0.i_up = up;
    @(posedge clk);
    model(clr, load, lb, en, up, 1'b1, c1, w1);
    model(clr, load, lb, en, up, 1'b0, c0, w0);
    mv = 1;
    #1;
    compare_all();
    if (en && !clr && !load && c1 != p1) check("ham1", $countones(if1.o_gray ^ g1), 1);
    if (en && !clr && !load && c0 != p0) check("ham0", $countones(if0.o_gray ^ g0), 1);
  endtask
  initial begin
    if1.i_clr = 0; if1.i_load = 0; if1.i_load_bin = 0; if1.i_en = 0; if1.i_up = 1;
    if0.i_clr = 0; if0.i_load = 0; if0.i_load_bin = 0; if0.i_en = 0; if0.i_up = 1;
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;
    #1;
    check("valid_before_edge", if1.o_valid, 0);
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 0, 1, 1);
      check("up_seq", if1.o_gray, seq[i]);
      check("up_wrap", if1.o_wrap, i == 15);
    end
    step(0, 1, 5, 1, 1);
    check("load_pri", if1.o_gray, 4'b0111);
    step(1, 1, 5, 1, 1);
    check("clr_pri", if1.o_gray, 0);
    step(0, 1, 0, 0, 1);
    step(0, 0, 0, 1, 0);
    check("down_wrap_gray", if1.o_gray, 4'b1000);
    check("down_wrap", if1.o_wrap, 1);
    check("down_sat", if0.o_gray, 0);
    step(0, 0, 0, 1, 0);
    check("down_wrap_end", if1.o_wrap, 0);
    step(0, 1, 14, 0, 1);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 1);
      pulses += int'(if0.o_wrap);
    end
    check("sat_gray", if0.o_gray, 4'b1000);
    check("sat_pulses", pulses, 1);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, M),
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    step(1, 0, 0, 0, 1);
    repeat (6) step(0, 0, 0, 1, 1);
    check("pre_rst_count", gray_to_binary(32'(if1.o_gray)), 6);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    c1 = 0; c0 = 0; w1 = 0; w0 = 0; mv = 0;
    compare_all();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0, 0, 0, 1, 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
